gray_codec_pipe: RTL and testbench
==================================

# gray_codec_pipe

Pipelined, elastic Gray/binary codec with a valid/ready handshake on both sides. It accepts one word per cycle and converts it in either direction, with the direction chosen per beat. The gray-to-binary prefix-XOR chain is split across a parametrised number of register stages so wide words close timing. For gray-to-binary beats it also checks that each new code differs from the previous one by at most one bit, and flags any violation. It sits after CDC pointer samplers and before counter/FIFO-level arithmetic.

## Interface
- DATA_WIDTH, 8, word width in bits; legal values are 2 to 64.
- STAGES, 2, number of pipeline register stages; legal values are 1 to DATA_WIDTH; sets the latency.
- CHK_EN, 1, enables the single-bit-step checker; when 0, err_o and err_sticky_o are tied to 0.
- clk_i  input  1  clock; single clock domain.
- rst_n_i  input  1  reset; asynchronous, active-low.
- flush_i  input  1  synchronous clear of the pipeline and the checker history.
- valid_i  input  1  input beat valid.
- ready_o  output  1  input beat accepted when valid_i && ready_o.
- mode_i  input  1  0 = GRAY2BIN, 1 = BIN2GRAY; sampled with the beat.
- data_i  input  DATA_WIDTH  input word.
- valid_o  output  1  output beat valid.
- ready_i  input  1  downstream ready.
- data_o  output  DATA_WIDTH  converted word.
- err_o  output  1  step violation on the current output beat; meaningful only while valid_o is high.
- err_sticky_o  output  1  at least one violation since the last reset or flush.

## Operation
- GRAY2BIN: bin[i] = XOR of gray[DATA_WIDTH-1:i].
  - Bits are split MSB-first into STAGES chunks of ceil(DATA_WIDTH/STAGES) bits; the last chunk may be shorter.
  - Stage s resolves chunk s using the lowest resolved bin bit of chunk s-1 as its carry.
- BIN2GRAY: gray = bin ^ (bin >> 1).
  - Computed in stage 0; later stages pass the result through.
- Mode, data and the error flag travel together through every stage.
- Checker (CHK_EN=1):
  - Keeps prev_gray and prev_vld, updated only on accepted GRAY2BIN beats.
  - For an accepted GRAY2BIN beat with prev_vld=1, err = popcount(data_i ^ prev_gray) > 1.
  - Distance 0 (unchanged code) is legal.
  - BIN2GRAY beats never set err and never update the history.
  - err_sticky_o sets together with the first valid_o && err_o beat.
- Elastic pipeline:
  - Each stage has its own valid bit.
  - A stage loads when it is empty or when its contents move on in the same cycle.
  - Last stage moves when ready_i=1.
  - ready_o = !vld[0] || stage 0 moves this cycle.
  - Full throughput is 1 beat/cycle; bubbles collapse.
- flush_i:
  - Clears every stage valid, prev_vld and err_sticky_o on the next edge.
  - ready_o is forced to 0 in the flush cycle, so no beat is accepted.
  - The output beat present in that cycle counts as delivered only if ready_i=1.
- Reset:
  - All stage valids, data registers, prev_gray, prev_vld and the sticky flag go to 0.
  - valid_o=0, data_o=0, err_o=0, err_sticky_o=0, ready_o=1.
- Reset asserted mid-stream discards all in-flight beats, with no output glitch beyond the asynchronous clear.

## Timing
- Latency: a beat accepted at edge N appears on valid_o/data_o after edge N+STAGES-1 when the pipeline is not stalled. With STAGES=1, data_o is registered one edge after acceptance.
- data_o, err_o and valid_o are all registered; no combinational path runs from data_i to data_o.
- ready_o depends combinationally on ready_i through the stall chain (one path per stage). This is accepted; no skid buffer.
- While valid_o && !ready_i, data_o and err_o hold stable. valid_o never drops without a handshake, except on flush or reset.
- Full pipeline plus ready_i=0: ready_o=0 in that cycle. ready_i rising re-opens ready_o in the same cycle.
- A simultaneous input and output handshake on a full pipeline moves every stage by one.

## Structure
- The shared package gray_pkg holds:
  - typedef enum logic {GRAY2BIN=1'b0, BIN2GRAY=1'b1} gray_mode_e;
  - the chunk-size and chunk-bound constant functions;
  - a popcount function.
- Sub-module gray_pipe_stage: one register stage holding valid, mode, data, err and a carry bit, plus the chunk-resolve logic for its index. It is instantiated STAGES times in a generate loop.
- The top level holds the handshake chain, the checker and the sticky flag.

## Test plan
- Reset (DATA_WIDTH=8, STAGES=2): valid_o=0, data_o=0x00, err_o=0, err_sticky_o=0, ready_o=1 during and after reset.
- Single beat GRAY2BIN 0xC0 -> data_o=0x80 two edges after acceptance, err_o=0. Single beat BIN2GRAY 0x80 -> 0xC0.
- Back-to-back GRAY2BIN 0x00, 0x01, 0x03, 0x02, 0x06 -> outputs 0,1,2,3,4 on consecutive cycles, err_o=0 throughout.
- GRAY2BIN 0x00 then 0x03 -> second output 0x02 with err_o=1; err_sticky_o=1 from then on. A following 0x03 repeat gives err_o=0.
- Backpressure: issue 4 beats while holding ready_i=0 for 5 cycles.
  - ready_o drops after 2 beats are accepted.
  - data_o stays stable while stalled.
  - After release, all 4 beats are delivered in order, with no loss or duplication.
- Flush with 2 beats in flight and err_sticky_o=1:
  - Next cycle: valid_o=0 and err_sticky_o=0.
  - The first GRAY2BIN beat after the flush (0xFF) gives err_o=0, and 0xFF converts to 0xAA.

Source files
------------

// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_pkg
//  Description : Shared types and constant helpers for the Gray/binary codec:
//                the per-beat conversion mode, the chunk split of the
//                gray-to-binary prefix-XOR chain across pipeline stages, and a
//                popcount used by the single-bit-step checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

    typedef enum logic {
        GRAY2BIN = 1'b0,
        BIN2GRAY = 1'b1
    } gray_mode_e;

    // Widest word the helpers below are written for.
    localparam int c_MAX_WIDTH = 64;

    // Bits resolved per stage: ceil(width / stages).
    function automatic int chunk_size(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    // Upper bit of chunk idx (MSB-first split). Negative when the chunk is
    // empty, which happens when STAGES does not divide the word evenly and
    // the earlier chunks already cover every bit.
    function automatic int chunk_hi(input int width, input int stages, input int idx);
        return width - 1 - idx * chunk_size(width, stages);
    endfunction

    // Lower bit of chunk idx, clamped at bit 0 so the last chunk may be short.
    function automatic int chunk_lo(input int width, input int stages, input int idx);
        int lo;
        lo = width - (idx + 1) * chunk_size(width, stages);
        return (lo < 0) ? 0 : lo;
    endfunction

    function automatic int unsigned popcount(input logic [c_MAX_WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < c_MAX_WIDTH; i++) begin
            if (v[i]) begin
                n++;
            end
        end
        return n;
    endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : gray_pipe_stage
//  Description : One register stage of the Gray/binary codec pipeline. Holds
//                valid, mode, data, error flag and the prefix-XOR carry, and
//                resolves its own chunk of the gray-to-binary chain on the way
//                in. Stage 0 also performs the whole binary-to-gray
//                conversion; later stages pass binary-to-gray beats through.
//  Ports       : i_clk, i_rst_n   clock, asynchronous active-low reset
//                i_flush          synchronous clear of valid and error
//                i_open           stage may load this cycle (from top chain)
//                i_up_*           beat arriving from upstream
//                o_*              registered stage contents
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_pipe_stage
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STAGES     = 2,
    parameter int IDX        = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_open,
    input  logic                  i_up_valid,
    input  gray_mode_e            i_up_mode,
    input  logic [DATA_WIDTH-1:0] i_up_data,
    input  logic                  i_up_err,
    input  logic                  i_up_carry,
    output logic                  o_valid,
    output gray_mode_e            o_mode,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_err,
    output logic                  o_carry
);

    localparam int c_HI = chunk_hi(DATA_WIDTH, STAGES, IDX);
    localparam int c_LO = chunk_lo(DATA_WIDTH, STAGES, IDX);

    logic                  r_valid;
    gray_mode_e            r_mode;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_err;
    logic                  r_carry;

    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_carry;

    // Bits above this chunk are already binary, bits below are still gray.
    // The carry is the lowest resolved binary bit of the previous chunk, so
    // walking this chunk MSB-first yields bin[b] = carry ^ gray[hi:b].
    always_comb begin
        w_data  = i_up_data;
        w_carry = i_up_carry;
        if (i_up_mode == GRAY2BIN) begin
            for (int b = DATA_WIDTH - 1; b >= 0; b--) begin
                if ((b <= c_HI) && (b >= c_LO)) begin
                    w_carry   = w_carry ^ i_up_data[b];
                    w_data[b] = w_carry;
                end
            end
        end else if (IDX == 0) begin
            w_data = i_up_data ^ (i_up_data >> 1);
        end
    end

    // Payload only loads with a real beat so the output holds steady while
    // the stage is stalled or idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_mode  <= GRAY2BIN;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_carry <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (i_open) begin
            r_valid <= i_up_valid;
            if (i_up_valid) begin
                r_mode  <= i_up_mode;
                r_data  <= w_data;
                r_err   <= i_up_err;
                r_carry <= w_carry;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_mode  = r_mode;
    assign o_data  = r_data;
    assign o_err   = r_err;
    assign o_carry = r_carry;

endmodule : gray_pipe_stage
`default_nettype wire

// File: rtl/gray_codec_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : gray_codec_pipe
//  Description : Pipelined, elastic Gray/binary codec with valid/ready on both
//                sides. Direction is chosen per beat. The gray-to-binary
//                prefix-XOR chain is split across STAGES register stages.
//                Gray-to-binary beats are checked for single-bit steps against
//                the previous gray-to-binary beat.
//  Ports       : clk_i, rst_n_i      clock, asynchronous active-low reset
//                flush_i             synchronous clear of pipeline + history
//                valid_i/ready_o     input handshake
//                mode_i, data_i      beat mode (0 gray->bin, 1 bin->gray), word
//                valid_o/ready_i     output handshake
//                data_o, err_o       converted word, step violation flag
//                err_sticky_o        any violation since reset or flush
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_codec_pipe
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STAGES     = 2,
    parameter int CHK_EN     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  mode_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  err_o,
    output logic                  err_sticky_o
);

    gray_mode_e            w_mode_in;
    logic                  w_accept;
    logic                  w_step_err;

    logic [STAGES-1:0]     w_vld;
    logic [STAGES-1:0]     w_open;
    logic [STAGES-1:0]     w_err;
    logic [STAGES-1:0]     w_carry;
    gray_mode_e            w_mode [STAGES];
    logic [DATA_WIDTH-1:0] w_data [STAGES];
    logic                  w_dn_ready;
    logic                  w_unused_tail;

    assign w_mode_in = gray_mode_e'(mode_i);

    // Stall chain, walked from the output back to the input: a stage may
    // load when it is empty or when whatever it holds moves on this cycle.
    always_comb begin
        w_open     = '0;
        w_dn_ready = ready_i;
        for (int s = STAGES - 1; s >= 0; s--) begin
            w_open[s]  = !w_vld[s] || w_dn_ready;
            w_dn_ready = w_open[s];
        end
    end

    assign ready_o  = w_open[0] && !flush_i;
    assign w_accept = valid_i && ready_o;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic                  w_up_valid;
        gray_mode_e            w_up_mode;
        logic [DATA_WIDTH-1:0] w_up_data;
        logic                  w_up_err;
        logic                  w_up_carry;

        if (s == 0) begin : g_head
            assign w_up_valid = valid_i;
            assign w_up_mode  = w_mode_in;
            assign w_up_data  = data_i;
            assign w_up_err   = w_step_err;
            assign w_up_carry = 1'b0;
        end else begin : g_body
            assign w_up_valid = w_vld[s-1];
            assign w_up_mode  = w_mode[s-1];
            assign w_up_data  = w_data[s-1];
            assign w_up_err   = w_err[s-1];
            assign w_up_carry = w_carry[s-1];
        end

        gray_pipe_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .STAGES     (STAGES),
            .IDX        (s)
        ) u_stage (
            .i_clk      (clk_i),
            .i_rst_n    (rst_n_i),
            .i_flush    (flush_i),
            .i_open     (w_open[s]),
            .i_up_valid (w_up_valid),
            .i_up_mode  (w_up_mode),
            .i_up_data  (w_up_data),
            .i_up_err   (w_up_err),
            .i_up_carry (w_up_carry),
            .o_valid    (w_vld[s]),
            .o_mode     (w_mode[s]),
            .o_data     (w_data[s]),
            .o_err      (w_err[s]),
            .o_carry    (w_carry[s])
        );
    end

    assign valid_o = w_vld[STAGES-1];
    assign data_o  = w_data[STAGES-1];
    assign err_o   = w_err[STAGES-1];

    // The last stage's carry and mode have no consumer.
    assign w_unused_tail = w_carry[STAGES-1] ^ w_mode[STAGES-1];

    if (CHK_EN != 0) begin : g_chk
        logic [DATA_WIDTH-1:0] r_prev_gray;
        logic                  r_prev_vld;
        logic                  r_sticky;
        logic [DATA_WIDTH-1:0] w_diff;

        assign w_diff = data_i ^ r_prev_gray;

        // Distance 0 (repeated code) is legal; only multi-bit jumps flag.
        assign w_step_err = (w_mode_in == GRAY2BIN) && r_prev_vld &&
                            (popcount(c_MAX_WIDTH'(w_diff)) > 32'd1);

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_prev_gray <= '0;
                r_prev_vld  <= 1'b0;
                r_sticky    <= 1'b0;
            end else if (flush_i) begin
                r_prev_vld  <= 1'b0;
                r_sticky    <= 1'b0;
            end else begin
                if (w_accept && (w_mode_in == GRAY2BIN)) begin
                    r_prev_gray <= data_i;
                    r_prev_vld  <= 1'b1;
                end
                if (valid_o && err_o) begin
                    r_sticky <= 1'b1;
                end
            end
        end

        // The OR term makes the sticky flag rise in the same cycle as the
        // first erroneous output beat rather than one cycle later.
        assign err_sticky_o = r_sticky || (valid_o && err_o);
    end else begin : g_nochk
        assign w_step_err   = 1'b0;
        assign err_sticky_o = 1'b0;
    end

endmodule : gray_codec_pipe
`default_nettype wire

// File: tb/tb_gray_codec_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_gray_codec_pipe
//  Description : Directed self-checking bench for gray_codec_pipe
//                (DATA_WIDTH=8, STAGES=2, CHK_EN=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_codec_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       valid_i;
    logic       ready_o;
    logic       mode;
    logic [7:0] data_i;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] data_o;
    logic       err_o;
    logic       err_sticky;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_deliv  = 0;
    logic [8:0] exp_q [$];   // {err, data} in delivery order

    always #5 clk = ~clk;

    gray_codec_pipe #(
        .DATA_WIDTH (8),
        .STAGES     (2),
        .CHK_EN     (1)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .flush_i      (flush),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .mode_i       (mode),
        .data_i       (data_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .err_o        (err_o),
        .err_sticky_o (err_sticky)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: samples mid-cycle, where it sees the values present at
    // the next rising edge.
    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_beat", 64'(exp_q.size()), 64'd1);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check_eq("out_data", 64'(data_o), 64'(e[7:0]));
                check_eq("out_err", 64'(err_o), 64'(e[8]));
                n_deliv++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic e, input logic [7:0] d);
        exp_q.push_back({e, d});
    endtask

    task automatic send(input logic m, input logic [7:0] d);
        int waited;
        waited  = 0;
        valid_i = 1'b1;
        mode    = m;
        data_i  = d;
        #1;
        while (!ready_o && waited < 50) begin
            tick();
            #1;
            waited++;
        end
        if (waited >= 50) begin
            check_eq("send_timeout", 64'(waited), 64'd0);
        end
        tick();
    endtask

    task automatic drain();
        int n;
        n       = 0;
        valid_i = 1'b0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic flush_pulse();
        valid_i = 1'b0;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_n   = 1'b1;
        flush   = 1'b0;
        valid_i = 1'b0;
        mode    = 1'b0;
        data_i  = 8'h00;
        ready_i = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        // Reset state, during reset
        check_eq("rst_valid_o", 64'(valid_o), 64'd0);
        check_eq("rst_data_o", 64'(data_o), 64'h00);
        check_eq("rst_err_o", 64'(err_o), 64'd0);
        check_eq("rst_sticky", 64'(err_sticky), 64'd0);
        check_eq("rst_ready_o", 64'(ready_o), 64'd1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        // Reset state, after release
        check_eq("post_rst_valid_o", 64'(valid_o), 64'd0);
        check_eq("post_rst_ready_o", 64'(ready_o), 64'd1);

        // Single GRAY2BIN beat 0xC0 -> 0x80, registered latency STAGES-1
        push_exp(1'b0, 8'h80);
        send(1'b0, 8'hC0);
        valid_i = 1'b0;
        #1;
        check_eq("lat_not_yet", 64'(valid_o), 64'd0);
        tick();
        check_eq("lat_valid", 64'(valid_o), 64'd1);
        check_eq("lat_data", 64'(data_o), 64'h80);
        // Single BIN2GRAY beat 0x80 -> 0xC0
        push_exp(1'b0, 8'hC0);
        send(1'b1, 8'h80);
        drain();
        flush_pulse();

        // Back-to-back legal gray sequence -> 0..4 on consecutive cycles
        d0 = n_deliv;
        push_exp(1'b0, 8'h00);
        push_exp(1'b0, 8'h01);
        push_exp(1'b0, 8'h02);
        push_exp(1'b0, 8'h03);
        push_exp(1'b0, 8'h04);
        send(1'b0, 8'h00);
        send(1'b0, 8'h01);
        send(1'b0, 8'h03);
        send(1'b0, 8'h02);
        send(1'b0, 8'h06);
        valid_i = 1'b0;
        tick();
        @(negedge clk);
        #1;
        check_eq("b2b_delivered", 64'(n_deliv - d0), 64'd5);
        drain();
        flush_pulse();
        check_eq("sticky_clear", 64'(err_sticky), 64'd0);

        // Two-bit jump flags err; repeated code is legal
        push_exp(1'b0, 8'h00);
        push_exp(1'b1, 8'h02);
        push_exp(1'b0, 8'h02);
        send(1'b0, 8'h00);
        send(1'b0, 8'h03);
        send(1'b0, 8'h03);
        drain();
        check_eq("sticky_set", 64'(err_sticky), 64'd1);

        // Backpressure: 4 beats, ready_i held low for 5 cycles
        push_exp(1'b0, 8'h02);
        push_exp(1'b0, 8'h03);
        push_exp(1'b0, 8'h04);
        push_exp(1'b0, 8'h05);
        ready_i = 1'b0;
        valid_i = 1'b1;
        mode    = 1'b0;
        data_i  = 8'h03;
        #1;
        check_eq("bp_ready_beat0", 64'(ready_o), 64'd1);
        tick();
        data_i = 8'h02;
        #1;
        check_eq("bp_ready_beat1", 64'(ready_o), 64'd1);
        tick();
        data_i = 8'h06;
        #1;
        check_eq("bp_full_ready", 64'(ready_o), 64'd0);
        check_eq("bp_full_valid", 64'(valid_o), 64'd1);
        check_eq("bp_hold_data0", 64'(data_o), 64'h02);
        tick();
        check_eq("bp_hold_data1", 64'(data_o), 64'h02);
        check_eq("bp_hold_ready", 64'(ready_o), 64'd0);
        tick();
        check_eq("bp_hold_data2", 64'(data_o), 64'h02);
        check_eq("bp_hold_err", 64'(err_o), 64'd0);
        tick();
        ready_i = 1'b1;
        #1;
        check_eq("bp_reopen", 64'(ready_o), 64'd1);
        tick();
        data_i = 8'h07;
        #1;
        check_eq("bp_stream_ready", 64'(ready_o), 64'd1);
        tick();
        drain();
        check_eq("bp_sticky_kept", 64'(err_sticky), 64'd1);

        // Flush with two beats in flight
        ready_i = 1'b0;
        send(1'b0, 8'h05);
        send(1'b0, 8'h04);
        valid_i = 1'b1;
        data_i  = 8'h00;
        flush   = 1'b1;
        #1;
        check_eq("flush_ready_o", 64'(ready_o), 64'd0);
        tick();
        flush   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        #1;
        check_eq("flush_valid_o", 64'(valid_o), 64'd0);
        check_eq("flush_sticky", 64'(err_sticky), 64'd0);
        push_exp(1'b0, 8'hAA);
        send(1'b0, 8'hFF);
        drain();
        repeat (5) tick();
        check_eq("final_valid_o", 64'(valid_o), 64'd0);
        check_eq("final_sticky", 64'(err_sticky), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_gray_codec_pipe
`default_nettype wire
